// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two W-bit operands (W = 4*NIBBLES) by reusing one 4-bit ripple slice, one nibble per cycle. Optional macro: OVERFLOW_FLAG_EN.
// Latency: operands accepted at edge k give out_valid after edge k+NIBBLES; peak rate is one result per NIBBLES+2 cycles.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready is sampled high.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   carry_out
`ifdef OVERFLOW_FLAG_EN
  , output logic                   overflow
`endif
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             carry_q;

    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_s;
    logic [4:0]       chain;

    // The single shared slice: chain[3] is the carry into the slice MSB, chain[4] its carry out.
    always_comb begin
        slice_a  = a_q[{idx, 2'b00} +: 4];
        slice_b  = b_q[{idx, 2'b00} +: 4];
        chain    = '0;
        slice_s  = '0;
        chain[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            slice_s[i]   = slice_a[i] ^ slice_b[i] ^ chain[i];
            chain[i + 1] = (slice_a[i] & slice_b[i]) | (chain[i] & (slice_a[i] ^ slice_b[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef OVERFLOW_FLAG_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= slice_s;
                    carry_q                <= chain[4];
                    if (idx == LAST_IDX) begin
                        // Top nibble: publish the result and park idx so it never wraps.
                        carry_out <= chain[4];
`ifdef OVERFLOW_FLAG_EN
                        overflow  <= chain[4] ^ chain[3];
`endif
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    idx       <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: arithmetic/queue-level model checked every cycle plus directed literal cases.
module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef OVERFLOW_FLAG_EN
    logic         overflow;
`endif

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef OVERFLOW_FLAG_EN
      , .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: busy from acceptance until the result is taken; result visible N edges after acceptance.
    bit           m_busy  = 1'b0;
    bit           m_valid = 1'b0;
    bit           m_zero  = 1'b1;
    int           m_cnt   = 0;
    logic [W-1:0] m_sum   = '0;
    logic         m_co    = 1'b0;
    logic         m_ovf   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_zero  = 1'b1;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        logic [W:0] tot;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (in_valid) begin
                tot     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_sum   = tot[W-1:0];
                m_co    = tot[W];
                m_ovf   = (a[W-1] == b[W-1]) && (m_sum[W-1] != a[W-1]);
                m_busy  = 1'b1;
                m_cnt   = 0;
                m_zero  = 1'b0;
            end
        end else if (!m_valid) begin
            m_cnt++;
            if (m_cnt == N) m_valid = 1'b1;
        end else if (out_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            #1;
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("sum", {16'd0, sum}, {16'd0, m_sum});
                check("carry_out", {31'd0, carry_out}, {31'd0, m_co});
`ifdef OVERFLOW_FLAG_EN
                check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`endif
            end
            if (m_zero) begin
                check("idle_sum_zero", {16'd0, sum}, 32'd0);
                check("idle_carry_zero", {31'd0, carry_out}, 32'd0);
            end
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tc,
                       input int hold, input logic [W-1:0] es, input logic ec, input logic eo,
                       input string nm);
        int lat;
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_op;
        cin       = tc;
        out_ready = 1'b0;
        wait_cycle();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            wait_cycle();
            lat++;
        end
        check({nm, "_latency"}, lat, N);
        check({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({nm, "_carry"}, {31'd0, carry_out}, {31'd0, ec});
`ifdef OVERFLOW_FLAG_EN
        check({nm, "_overflow"}, {31'd0, overflow}, {31'd0, eo});
`else
        if (eo) $display("note: %s expects overflow, flag not built", nm);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111;
            wait_cycle();
            check({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({nm, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
            check({nm, "_hold_sum"}, {16'd0, sum}, {16'd0, es});
            check({nm, "_hold_carry"}, {31'd0, carry_out}, {31'd0, ec});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_cycle();
        out_ready = 1'b0;
        check({nm, "_back_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        wait_cycle();
        wait_cycle();
        rst_n = 1'b1;
        wait_cycle();

        txn(16'h0000, 16'h0000, 1'b0, 0, 16'h0000, 1'b0, 1'b0, "zero");
        txn(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0, "ripple");
        txn(16'h1234, 16'h0FED, 1'b1, 5, 16'h2222, 1'b0, 1'b0, "mixed");
        txn(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1, "signed_ovf");

        // Abort during the second RUN cycle.
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h1111;
        cin      = 1'b0;
        wait_cycle();
        in_valid = 1'b0;
        wait_cycle();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_carry", {31'd0, carry_out}, 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) wait_cycle();
        txn(16'h0003, 16'h0005, 1'b0, 0, 16'h0008, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            wait_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) wait_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
